riscv_proc_dpath_regfile_sb: RTL



---
 rtl/riscv_proc_dpath_regfile_sb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/riscv_proc_dpath_regfile_sb.sv
// Multi-port integer register file with a per-entry busy-bit scoreboard and a
// hardware zero-initialisation sweep that runs after every reset.
module riscv_proc_dpath_regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 init_done,
  input  logic [NRD*AW-1:0]    raddr,
  input  logic [NRD-1:0]       ren,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST_W = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE_W  = AW'(1);

  state_t              state_r, state_s;
  logic [AW-1:0]       cnt_r, cnt_s;
  logic                init_done_r;
  logic [XLEN-1:0]     mem_r [NREG];
  logic [NREG-1:0]     mem_we_s;
  logic [XLEN-1:0]     mem_wd_s [NREG];
  logic [NREG-1:0]     busy_r, busy_s;
  logic [NRD*XLEN-1:0] rdata_s;
  logic [NRD-1:0]      rbusy_s;

  // Entry 0 is hardwired zero, so it never counts as a real target.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != {AW{1'b0}}) && ({1'b0, a} < NREG_W);
  endfunction

  // Sweep counter and INIT -> RUN transition on the edge that clears the last entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_s = cnt_r + ONE_W;
        if (cnt_r == LAST_W) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_INIT;
    endcase
  end

  // Control state, sweep counter and init_done flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= {AW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      init_done_r <= (state_s == ST_RUN);
    end
  end

  // Per-entry write decode; later ports override earlier ones on collision.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      mem_we_s[k] = 1'b0;
      mem_wd_s[k] = {XLEN{1'b0}};
      if (state_r == ST_INIT) begin
        mem_we_s[k] = (cnt_r == AW'(k));
      end else begin
        for (int j = 0; j < NWR; j++) begin
          mem_we_s[k] = mem_we_s[k] |
                        (wen[j] && addr_ok(waddr[j*AW +: AW]) && (waddr[j*AW +: AW] == AW'(k)));
          mem_wd_s[k] = (wen[j] && addr_ok(waddr[j*AW +: AW]) && (waddr[j*AW +: AW] == AW'(k)))
                        ? wdata[j*XLEN +: XLEN] : mem_wd_s[k];
        end
      end
    end
  end

  // Register array; contents are rebuilt by the sweep, so no reset is needed here.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREG; k++) begin
      if (mem_we_s[k]) begin
        mem_r[k] <= mem_wd_s[k];
      end
    end
  end

  // Busy update: writeback clears, issue sets, and set beats a same-cycle clear.
  always_comb begin
    busy_s = busy_r;
    if (state_r == ST_RUN) begin
      for (int k = 1; k < NREG; k++) begin
        for (int j = 0; j < NWR; j++) begin
          busy_s[k] = busy_s[k] & ~(wen[j] && (waddr[j*AW +: AW] == AW'(k)));
        end
        busy_s[k] = busy_s[k] | (sb_set && (sb_addr == AW'(k)));
      end
      busy_s[0] = 1'b0;
    end else begin
      busy_s = {NREG{1'b0}};
    end
  end

  // Scoreboard busy bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_s;
    end
  end

  // Combinational read ports with optional same-cycle writeback forwarding.
  always_comb begin
    rdata_s = {(NRD*XLEN){1'b0}};
    rbusy_s = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if ((state_r == ST_RUN) && ren[i] && addr_ok(raddr[i*AW +: AW])) begin
        rdata_s[i*XLEN +: XLEN] = mem_r[raddr[i*AW +: AW]];
        rbusy_s[i]              = busy_r[raddr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          rdata_s[i*XLEN +: XLEN] =
            ((BYPASS != 0) && wen[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]))
            ? wdata[j*XLEN +: XLEN] : rdata_s[i*XLEN +: XLEN];
          rbusy_s[i] =
            ((BYPASS != 0) && wen[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]))
            ? 1'b0 : rbusy_s[i];
        end
      end else begin
        rdata_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rbusy_s[i]              = 1'b0;
      end
    end
  end

  assign rdata     = rdata_s;
  assign rbusy     = rbusy_s;
  assign init_done = init_done_r;

endmodule
